// File: rtl/ctrl_ramdrv_head_bank.sv
// Per-channel circular-buffer head/length bank with modular head advance and tap read.
// Latency: writes take effect at the next edge; read result and rd_valid one cycle after read_reg.
// Backpressure: none; one command and one read are accepted every cycle, illegal ones pulse cmd_err.
module ctrl_ramdrv_head_bank #(
  parameter int DATA_OFFSET_WIDTH  = 10,
  parameter int VECTOR_INDEX_WIDTH = 4,
  parameter int STEP_WIDTH         = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          init,
  input  logic                          clear,
  input  logic                          head_inc,
  input  logic                          read_reg,
  input  logic [VECTOR_INDEX_WIDTH-1:0] index,
  input  logic [VECTOR_INDEX_WIDTH-1:0] rd_index,
  input  logic [DATA_OFFSET_WIDTH-1:0]  length,
  input  logic [STEP_WIDTH-1:0]         step,
  input  logic [DATA_OFFSET_WIDTH-1:0]  rd_tap,
  output logic [DATA_OFFSET_WIDTH-1:0]  head_offset,
  output logic                          rd_valid,
  output logic                          cmd_err
);

  localparam int W   = DATA_OFFSET_WIDTH;
  localparam int NCH = 2**VECTOR_INDEX_WIDTH;

  // Per-channel state. Invariant: r_head[ch] <= r_len[ch] at all times.
  logic [W-1:0] r_head [NCH];
  logic [W-1:0] r_len  [NCH];

  // Write-side decode
  logic [1:0]   w_cmd_cnt;
  logic         w_multi;
  logic [W-1:0] w_wr_head;
  logic [W-1:0] w_wr_len;
  logic [W:0]   w_wr_size;
  logic [W:0]   w_step_ext;
  logic [W:0]   w_inc_sum;
  logic         w_inc_err;
  logic [W-1:0] w_inc_next;

  // Read-side decode
  logic [W-1:0] w_rd_head;
  logic [W-1:0] w_rd_len;
  logic [W:0]   w_rd_sum;
  logic         w_rd_err;
  logic [W-1:0] w_rd_res;

  // Command legality and the modular head advance for the write channel.
  always_comb begin
    w_cmd_cnt  = {1'b0, init} + {1'b0, clear} + {1'b0, head_inc};
    w_multi    = (w_cmd_cnt > 2'd1);
    w_wr_head  = r_head[index];
    w_wr_len   = r_len[index];
    w_wr_size  = {1'b0, w_wr_len} + {{W{1'b0}}, 1'b1};
    w_step_ext = {{(W+1-STEP_WIDTH){1'b0}}, step};
    w_inc_sum  = {1'b0, w_wr_head} + w_step_ext;
    // A step larger than the buffer would wrap more than once; refuse it.
    w_inc_err  = head_inc && !w_multi && (w_step_ext > w_wr_size);
    // head <= len and step <= len+1 keep the wrapped result within W bits,
    // so the subtraction can be done modulo 2**W.
    if (w_inc_sum > {1'b0, w_wr_len}) begin
      w_inc_next = w_inc_sum[W-1:0] - w_wr_len - W'(1);
    end else begin
      w_inc_next = w_inc_sum[W-1:0];
    end
  end

  // Tap-offset address for the read channel, using pre-edge head/len.
  always_comb begin
    w_rd_head = r_head[rd_index];
    w_rd_len  = r_len[rd_index];
    w_rd_sum  = {1'b0, w_rd_head} + {1'b0, rd_tap};
    w_rd_err  = read_reg && (rd_tap > w_rd_len);
    if (w_rd_err) begin
      w_rd_res = '0;
    end else if (w_rd_sum > {1'b0, w_rd_len}) begin
      w_rd_res = w_rd_sum[W-1:0] - w_rd_len - W'(1);
    end else begin
      w_rd_res = w_rd_sum[W-1:0];
    end
  end

  // Channel state update; any multi-command cycle leaves state untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_head[i] <= '0;
        r_len[i]  <= '0;
      end
    end else if (!w_multi) begin
      if (init) begin
        r_len[index] <= length;
        if (w_wr_head > length) begin
          r_head[index] <= '0;
        end
      end else if (clear) begin
        r_head[index] <= '0;
      end else if (head_inc && !w_inc_err) begin
        r_head[index] <= w_inc_next;
      end
    end
  end

  // Registered read port; result holds when no read is requested.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_offset <= '0;
      rd_valid    <= 1'b0;
    end else begin
      rd_valid <= read_reg;
      if (read_reg) begin
        head_offset <= w_rd_res;
      end
    end
  end

  // Single-cycle error pulse collecting every error source of the cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_err <= 1'b0;
    end else begin
      cmd_err <= w_multi | w_inc_err | w_rd_err;
    end
  end

endmodule

// File: tb/tb_ctrl_ramdrv_head_bank.sv
// Bench for ctrl_ramdrv_head_bank: directed scenarios plus random traffic vs. an arithmetic model.
// Latency: checks outputs 1 ns after each rising edge against the model's one-cycle-late results.
// Backpressure: none; the bench drives one command and one read per cycle.
module tb_ctrl_ramdrv_head_bank;

  localparam int W   = 10;
  localparam int VIW = 4;
  localparam int SW  = 3;
  localparam int NCH = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           init, clear, head_inc, read_reg;
  logic [VIW-1:0] index, rd_index;
  logic [W-1:0]   length;
  logic [SW-1:0]  step;
  logic [W-1:0]   rd_tap;
  logic [W-1:0]   head_offset;
  logic           rd_valid;
  logic           cmd_err;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_head [NCH];
  int m_len  [NCH];
  int m_off;

  ctrl_ramdrv_head_bank #(
    .DATA_OFFSET_WIDTH (W),
    .VECTOR_INDEX_WIDTH(VIW),
    .STEP_WIDTH        (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .init       (init),
    .clear      (clear),
    .head_inc   (head_inc),
    .read_reg   (read_reg),
    .index      (index),
    .rd_index   (rd_index),
    .length     (length),
    .step       (step),
    .rd_tap     (rd_tap),
    .head_offset(head_offset),
    .rd_valid   (rd_valid),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic idle();
    init = 0; clear = 0; head_inc = 0; read_reg = 0;
    index = '0; rd_index = '0; length = '0; step = '0; rd_tap = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_head[i] = 0;
      m_len[i]  = 0;
    end
    m_off = 0;
  endtask

  // One clock: model computes from pre-edge state, then outputs are compared.
  task automatic tick();
    int nset, e_valid, e_err, ci, ri, h, l, t;
    @(posedge clk);
    ci   = int'(index);
    ri   = int'(rd_index);
    nset = int'(init) + int'(clear) + int'(head_inc);
    e_err = (nset >= 2) ? 1 : 0;
    if (nset == 1 && head_inc && int'(step) > m_len[ci] + 1) e_err = 1;
    e_valid = read_reg ? 1 : 0;
    if (read_reg) begin
      h = m_head[ri]; l = m_len[ri]; t = int'(rd_tap);
      if (t > l) begin
        m_off = 0;
        e_err = 1;
      end else begin
        m_off = (h + t) % (l + 1);
      end
    end
    if (nset == 1) begin
      if (init) begin
        m_len[ci] = int'(length);
        if (m_head[ci] > int'(length)) m_head[ci] = 0;
      end else if (clear) begin
        m_head[ci] = 0;
      end else if (int'(step) <= m_len[ci] + 1) begin
        m_head[ci] = (m_head[ci] + int'(step)) % (m_len[ci] + 1);
      end
    end
    #1;
    chk("rd_valid", rd_valid, e_valid);
    chk("head_offset", head_offset, m_off);
    chk("cmd_err", cmd_err, e_err);
  endtask

  task automatic do_init(input int ch, input int len);
    idle(); init = 1; index = VIW'(ch); length = W'(len); tick();
  endtask

  task automatic do_inc(input int ch, input int s);
    idle(); head_inc = 1; index = VIW'(ch); step = SW'(s); tick();
  endtask

  task automatic do_read(input int ch, input int tap);
    idle(); read_reg = 1; rd_index = VIW'(ch); rd_tap = W'(tap); tick();
  endtask

  initial begin
    int exp3 [4];
    int op, ch, lr;
    exp3[0] = 3; exp3[1] = 6; exp3[2] = 9; exp3[3] = 2;
    idle();
    model_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", rd_valid, 0);
    chk("reset_offset", head_offset, 0);
    chk("reset_err", cmd_err, 0);
    @(negedge clk);
    rst = 0;

    // Every channel reads 0 after reset
    for (int c = 0; c < NCH; c++) begin
      do_read(c, 0);
      chk("reset_read_ch", head_offset, 0);
    end

    // ch3: length 9, step 3 wraps 9 -> 2
    do_init(3, 9);
    for (int k = 0; k < 4; k++) begin
      do_inc(3, 3);
      do_read(3, 0);
      chk("ch3_head", head_offset, exp3[k]);
    end

    // ch5: length 7, head 6, tap wrap and tap out of range
    do_init(5, 7);
    do_inc(5, 6);
    do_read(5, 4);
    chk("ch5_tap4", head_offset, 2);
    do_read(5, 8);
    chk("ch5_tap8_off", head_offset, 0);
    chk("ch5_tap8_err", cmd_err, 1);
    idle(); tick();
    chk("ch5_err_clears", cmd_err, 0);

    // ch2: oversize step and multi-command rejection
    do_init(2, 4);
    do_inc(2, 1);
    do_inc(2, 6);
    chk("ch2_step_err", cmd_err, 1);
    idle(); tick();
    chk("ch2_err_one_cycle", cmd_err, 0);
    idle(); init = 1; head_inc = 1; index = 2; length = 0; step = 1; tick();
    chk("ch2_multi_err", cmd_err, 1);
    do_read(2, 0);
    chk("ch2_unchanged", head_offset, 1);

    // ch1: shrink length, read-before-write, channel isolation
    do_init(1, 9);
    do_inc(1, 7);
    do_inc(1, 1);
    do_read(1, 0);
    chk("ch1_head8", head_offset, 8);
    do_init(1, 5);
    do_read(1, 0);
    chk("ch1_shrunk", head_offset, 0);
    do_inc(1, 3);
    idle(); head_inc = 1; index = 1; step = 2; read_reg = 1; rd_index = 1; tick();
    chk("ch1_old_value", head_offset, 3);
    do_read(1, 0);
    chk("ch1_new_value", head_offset, 5);
    do_init(0, 3);
    do_inc(0, 2);
    do_read(1, 0);
    chk("ch1_isolated", head_offset, 5);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      idle();
      op = $urandom_range(0, 9);
      ch = $urandom_range(0, NCH - 1);
      index = VIW'(ch);
      lr = ($urandom_range(0, 15) == 0) ? 1023 : $urandom_range(0, 12);
      length = W'(lr);
      step = SW'($urandom_range(0, 7));
      case (op)
        0, 1:       init = 1;
        2:          clear = 1;
        3, 4, 5, 6: head_inc = 1;
        7: begin
          init = 1; head_inc = $urandom_range(0, 1);
          clear = head_inc ? $urandom_range(0, 1) : 1'b1;
        end
        default: ;
      endcase
      read_reg = ($urandom_range(0, 2) != 0);
      rd_index = VIW'($urandom_range(0, NCH - 1));
      if (m_len[rd_index] >= 1021) rd_tap = W'($urandom_range(0, 1023));
      else rd_tap = W'($urandom_range(0, m_len[rd_index] + 2));
      tick();
    end

    // Asynchronous reset in the middle of a read burst
    for (int c = 0; c < NCH; c++) begin
      idle(); head_inc = 1; index = VIW'(c); step = 1; tick();
    end
    for (int k = 0; k < 3; k++) do_read(k + 4, 0);
    idle(); read_reg = 1; rd_index = 4;
    #3;
    rst = 1;
    #1;
    chk("arst_valid", rd_valid, 0);
    chk("arst_offset", head_offset, 0);
    chk("arst_err", cmd_err, 0);
    model_reset();
    idle();
    @(posedge clk);
    #1;
    chk("arst_hold_valid", rd_valid, 0);
    @(negedge clk);
    rst = 0;
    for (int c = 0; c < NCH; c++) begin
      do_read(c, 0);
      chk("post_arst_read", head_offset, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_ramdrv_head_bank.md
Name: ctrl_ramdrv_head_bank

Overview:
- Multi-channel circular-buffer head-pointer bank for the RAM driver in the controller.
- Each channel holds its own buffer length and head offset.
- Head advances by a programmable step with modular wrap-around, for decimating and interpolating channels.
- A registered read port returns head+tap modulo buffer size, so FIR delay-line addresses come straight from the bank.
- Replaces the single-shared-length, tri-state-output head register block.

Parameters:
- DATA_OFFSET_WIDTH, 10: width W of head, length, tap and read offset.
- VECTOR_INDEX_WIDTH, 4: channel index width; NCH = 2**VECTOR_INDEX_WIDTH channels.
- STEP_WIDTH, 3: width of head increment step.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- init  in  1  load length for channel index.
- clear  in  1  force head of channel index to 0.
- head_inc  in  1  advance head of channel index by step.
- read_reg  in  1  read request for channel rd_index.
- index  in  VECTOR_INDEX_WIDTH  target channel for init/clear/head_inc.
- rd_index  in  VECTOR_INDEX_WIDTH  channel for read.
- length  in  W  last valid offset; buffer size is length+1.
- step  in  STEP_WIDTH  increment amount, 0..2**STEP_WIDTH-1.
- rd_tap  in  W  offset added to head on read.
- head_offset  out  W  registered read result.
- rd_valid  out  1  head_offset valid this cycle.
- cmd_err  out  1  one-cycle pulse on illegal command.

Behaviour:
- Reset (async, rst=1): all head[ch]=0, len[ch]=0, head_offset=0, rd_valid=0, cmd_err=0. A reset mid-operation aborts any pending read; rd_valid falls immediately.
- Write command set {init, clear, head_inc}:
  - At most one of these may be high per cycle.
  - If two or more are high: no state change, cmd_err=1 next cycle.
- init: len[index] <= length. If head[index] > length, head[index] <= 0 in the same edge; otherwise head is kept.
- clear: head[index] <= 0; len is unchanged.
- head_inc:
  - Compute sum = head[index] + step using W+1 bits.
  - If sum > len[index]: head <= sum - (len[index]+1); otherwise head <= sum.
  - Illegal if step > len[index]+1: head is unchanged and cmd_err pulses.
  - step=0 is legal (hold).
  - len=0 means the head always stays 0.
- Read (independent of the write commands):
  - Latency 1. When read_reg=1 at edge N, at edge N+1 rd_valid=1 and head_offset = (head[rd_index] + rd_tap) mod (len[rd_index]+1), using the pre-edge-N head.
  - If rd_tap > len[rd_index]: head_offset=0, rd_valid=1, cmd_err pulses.
  - When read_reg=0: rd_valid=0 next cycle and head_offset holds its last value.
  - Back-to-back reads give one result per cycle.
- Simultaneous read and write, same channel: the read sees the old head/len (read-before-write). Different channels are fully independent.
- cmd_err is the OR of all error sources in that cycle, registered, one cycle wide.
- No combinational path from any input to any output.
- Sequential logic is confined to head[], len[], head_offset, rd_valid and cmd_err. The modular arithmetic is single-cycle; there is no extra pipelining.

Test Plan:
- Reset then read every channel with tap=0 -> head_offset=0, rd_valid=1 one cycle after each read_reg; cmd_err never high.
- ch3 init length=9; head_inc step=3 four times -> heads 3,6,9,2; read tap=0 after each step gives those values.
- ch5 length=7, head=6; read rd_tap=4 -> head_offset=2; rd_tap=8 -> head_offset=0, cmd_err pulse.
- ch2 length=4, head_inc step=6 -> head unchanged, cmd_err=1 for exactly one cycle; init+head_inc asserted together -> no state change, cmd_err.
- ch1 head=8 (length=9); init length=5 -> head=0; same-cycle head_inc on ch1 with read_reg on ch1 -> read returns old value, next read returns the incremented value; ops on ch0 leave ch1 untouched.
- Assert rst asynchronously between edges during a read burst -> rd_valid and head_offset drop to 0 immediately; all channels read 0 after release.
